// File: rtl/dac8411_pkg.sv
// Shared types and frame geometry for the DAC8411 serial writer.
package dac8411_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    GAP
  } state_t;

  localparam int FRAME_BITS = 24;
  localparam int CODE_BITS  = 16;
  localparam int PAD_BITS   = FRAME_BITS - 2 - CODE_BITS;

endpackage

// File: rtl/dac8411_serial_writer.sv
// Free-running DAC8411 frame transmitter: {PD1:PD0, code, 6 pad zeros}, MSB first,
// sclk = clk/2, data launched with the sclk rising edge, DAC samples on the falling edge.
module dac8411_serial_writer
  import dac8411_pkg::*;
#(
  parameter int         DAC_WIDTH  = 16,
  parameter logic [1:0] PD_MODE    = 2'b00,
  parameter int         GAP_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 aresetn,
  input  logic [DAC_WIDTH-1:0] data_in,
  output logic                 sclk,
  output logic                 serial_data_out,
  output logic                 syncn
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  state_t                  state;
  logic [FRAME_BITS-2:0]   shreg;
  logic [4:0]              bit_cnt;
  logic                    phase;
  logic [GW-1:0]           gap_cnt;
  logic [FRAME_BITS-1:0]   frame;

  assign frame = {PD_MODE, data_in, {PAD_BITS{1'b0}}};

  // frame[MSB] goes straight to the pin in LOAD, so the shift register holds only the rest
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state           <= IDLE;
      shreg           <= '0;
      bit_cnt         <= '0;
      phase           <= 1'b0;
      gap_cnt         <= '0;
      sclk            <= 1'b0;
      serial_data_out <= 1'b0;
      syncn           <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          state <= LOAD;
        end
        LOAD: begin
          shreg           <= frame[FRAME_BITS-2:0];
          syncn           <= 1'b0;
          sclk            <= 1'b0;
          serial_data_out <= frame[FRAME_BITS-1];
          bit_cnt         <= '0;
          phase           <= 1'b0;
          state           <= SHIFT;
        end
        SHIFT: begin
          if (!phase) begin
            sclk  <= 1'b1;
            phase <= 1'b1;
            if (bit_cnt != 5'd0) begin
              serial_data_out <= shreg[FRAME_BITS-2];
              shreg           <= {shreg[FRAME_BITS-3:0], 1'b0};
            end
          end else begin
            sclk    <= 1'b0;
            phase   <= 1'b0;
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt == 5'(FRAME_BITS - 1)) begin
              state   <= GAP;
              gap_cnt <= '0;
            end
          end
        end
        GAP: begin
          syncn           <= 1'b1;
          sclk            <= 1'b0;
          serial_data_out <= 1'b0;
          if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
            state <= LOAD;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dac8411_serial_writer.sv
// Scoreboard bench for dac8411_serial_writer: two instances (PD_MODE 00 and 11) share stimulus;
// per-instance monitors decode frames on sclk falling edges and compare against queued frames.
module tb_dac8411_serial_writer;

  logic        clk = 1'b0;
  logic        aresetn;
  logic [15:0] data_in;
  logic        sclk0, sdo0, syncn0;
  logic        sclk1, sdo1, syncn1;

  int total = 0;
  int bad   = 0;

  logic [23:0] expq [2][$];
  logic        syncn_v [2];
  logic        sclk_v  [2];
  logic        sdo_v   [2];

  assign syncn_v[0] = syncn0;
  assign syncn_v[1] = syncn1;
  assign sclk_v[0]  = sclk0;
  assign sclk_v[1]  = sclk1;
  assign sdo_v[0]   = sdo0;
  assign sdo_v[1]   = sdo1;

  always #5 clk = ~clk;

  dac8411_serial_writer #(.DAC_WIDTH(16), .PD_MODE(2'b00), .GAP_CYCLES(4)) dut0 (
    .clk(clk), .aresetn(aresetn), .data_in(data_in),
    .sclk(sclk0), .serial_data_out(sdo0), .syncn(syncn0)
  );

  dac8411_serial_writer #(.DAC_WIDTH(16), .PD_MODE(2'b11), .GAP_CYCLES(4)) dut1 (
    .clk(clk), .aresetn(aresetn), .data_in(data_in),
    .sclk(sclk1), .serial_data_out(sdo1), .syncn(syncn1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] exp_frame(input logic [1:0] pd, input logic [15:0] d);
    return {pd, d, 6'b000000};
  endfunction

  task automatic push(input logic [23:0] e0, input logic [23:0] e1);
    expq[0].push_back(e0);
    expq[1].push_back(e1);
  endtask

  task automatic wait_rise();
    logic prev;
    prev = syncn0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!prev && syncn0) return;
      prev = syncn0;
    end
    chk("syncn_rise_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_fall();
    logic prev;
    prev = syncn0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (prev && !syncn0) return;
      prev = syncn0;
    end
    chk("syncn_fall_timeout", 32'd0, 32'd1);
  endtask

  task automatic send(input logic [15:0] d);
    wait_rise();
    data_in = d;
    push(exp_frame(2'b00, d), exp_frame(2'b11, d));
  endtask

  task automatic monitor(input int id);
    logic        prev_syncn, prev_sclk, sdo_hi, in_frame, gap_valid, viol;
    logic [23:0] bits, exp;
    int          nbits, low_len, high_len;
    prev_syncn = 1'b1; prev_sclk = 1'b0; sdo_hi = 1'b0; in_frame = 1'b0;
    gap_valid = 1'b0; viol = 1'b0; bits = '0; nbits = 0; low_len = 0; high_len = 0;
    forever begin
      @(negedge clk);
      if (!aresetn) begin
        // an aborted frame will never complete, so its expectation is discarded
        if (in_frame && expq[id].size() > 0) void'(expq[id].pop_front());
        in_frame = 1'b0; gap_valid = 1'b0; prev_syncn = 1'b1; prev_sclk = 1'b0;
        high_len = 0;
        continue;
      end
      if (syncn_v[id] && sclk_v[id]) viol = 1'b1;
      if (prev_syncn && !syncn_v[id]) begin
        if (gap_valid) chk($sformatf("gap_len%0d", id), high_len, 4);
        in_frame = 1'b1; nbits = 0; bits = '0; low_len = 0;
      end
      if (in_frame && !syncn_v[id]) begin
        low_len++;
        if (sclk_v[id]) sdo_hi = sdo_v[id];
        if (prev_sclk && !sclk_v[id]) begin
          chk($sformatf("sdo_stable%0d", id), sdo_v[id], sdo_hi);
          bits = {bits[22:0], sdo_v[id]};
          nbits++;
        end
      end
      if (!prev_syncn && syncn_v[id] && in_frame) begin
        if (expq[id].size() == 0) begin
          chk($sformatf("unexpected_frame%0d", id), bits, 32'hFFFFFFFF);
        end else begin
          exp = expq[id].pop_front();
          chk($sformatf("frame%0d", id), bits, exp);
        end
        chk($sformatf("nbits%0d", id), nbits, 24);
        chk($sformatf("syncn_low_len%0d", id), low_len, 49);
        chk($sformatf("sclk_idle%0d", id), viol, 1'b0);
        in_frame = 1'b0; gap_valid = 1'b1; high_len = 0; viol = 1'b0;
      end
      if (syncn_v[id]) high_len++;
      prev_syncn = syncn_v[id];
      prev_sclk  = sclk_v[id];
    end
  endtask

  initial fork
    monitor(0);
    monitor(1);
  join_none

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  logic [15:0] vec [10] = '{16'h0001, 16'h8000, 16'h7FFE, 16'h5A5A, 16'hA5A5,
                            16'h00FF, 16'hFF00, 16'h0F0F, 16'hDEAD, 16'hBEEF};

  initial begin
    aresetn = 1'b0;
    data_in = 16'hAAAA;
    push(24'h2AAA80, 24'hEAAA80);
    @(negedge clk);
    chk("rst_syncn", syncn0, 1'b1);
    chk("rst_sclk", sclk0, 1'b0);
    chk("rst_sdo", sdo0, 1'b0);
    aresetn = 1'b1;
    @(negedge clk);
    chk("idle_syncn", syncn0, 1'b1);
    @(negedge clk);
    chk("load_syncn", syncn0, 1'b0);

    send(16'hFFFF);
    expq[0][$] = 24'h3FFFC0; expq[1][$] = 24'hFFFFC0;
    send(16'h0000);
    expq[0][$] = 24'h000000; expq[1][$] = 24'hC00000;
    send(16'h1234);
    expq[0][$] = 24'h048D00; expq[1][$] = 24'hC48D00;

    // change the code mid-SHIFT of the 1234 frame
    wait_fall();
    repeat (10) @(negedge clk);
    data_in = 16'h5678;
    push(24'h159E00, 24'hD59E00);
    wait_rise();

    send(16'hABCD);
    wait_fall();
    repeat (21) @(negedge clk);
    #2 aresetn = 1'b0;
    #1;
    chk("async_rst_syncn0", syncn0, 1'b1);
    chk("async_rst_sclk0", sclk0, 1'b0);
    chk("async_rst_sdo0", sdo0, 1'b0);
    chk("async_rst_syncn1", syncn1, 1'b1);
    chk("async_rst_sclk1", sclk1, 1'b0);
    chk("async_rst_sdo1", sdo1, 1'b0);
    repeat (2) @(negedge clk);
    data_in = 16'hC3A5;
    push(24'h30E940, 24'hF0E940);
    aresetn = 1'b1;
    @(negedge clk);
    chk("rel_idle_syncn", syncn0, 1'b1);
    @(negedge clk);
    chk("rel_load_syncn", syncn0, 1'b0);

    for (int i = 0; i < 10; i++) send(vec[i]);
    wait_rise();
    @(negedge clk);
    chk("q0_empty", expq[0].size(), 0);
    chk("q1_empty", expq[1].size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
